lab4_control_sequencer: RTL and testbench

Multicycle control sequencer that drives the RF/ALU/DM datapath (RFALUDM_Lab4c) from encoded LEGv8 instructions; it produces the control strobes and field selects that are currently applied by hand from a bench.
- Accepts one 32-bit instruction through a valid/ready handshake.
- Decodes R-type ADD/SUB/AND/ORR and D-type LDUR/STUR.
- Steps the datapath through EXEC/MEM/WB cycles, then pulses Done.

---
 rtl/lab4_control_sequencer.sv | 160 ++++++++++++++++
 tb/tb_lab4_control_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lab4_control_sequencer.sv
// Multicycle LEGv8 control sequencer for the RF/ALU/DM datapath.
// Takes one instruction per handshake, walks DECODE/EXEC/MEM/WB, then retires it.
module lab4_control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [31:0]      Instr,
  input  logic             InstrValid,
  output logic             InstrReady,
  output logic [4:0]       Read1,
  output logic [4:0]       Rm,
  output logic [4:0]       Rt,
  output logic [4:0]       WriteReg,
  output logic [8:0]       SEin,
  output logic [10:0]      OpcodeField,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrc,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       Reg2Loc,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Done,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             regwrite_q, regwrite_d;
  logic             memread_q, memread_d;
  logic             memwrite_q, memwrite_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic [10:0] opc;
  logic        is_r, is_ldur, is_stur, is_legal, in_err;
  logic        unused_bits;

  assign opc         = instr_q[31:21];
  assign is_r        = (opc == OPC_ADD) || (opc == OPC_SUB) ||
                       (opc == OPC_AND) || (opc == OPC_ORR);
  assign is_ldur     = (opc == OPC_LDUR);
  assign is_stur     = (opc == OPC_STUR);
  assign is_legal    = is_r || is_ldur || is_stur;
  assign in_err      = (state_q == S_ERR);
  assign unused_bits = ^instr_q[11:10];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (InstrValid) begin
          instr_d = Instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_ERR;
      S_EXEC:   state_d = is_r ? S_WB : S_MEM;
      S_MEM:    state_d = is_ldur ? S_WB : S_DONE;
      S_WB:     state_d = S_DONE;
      S_DONE: begin
        count_d = count_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they come straight off flops.
  always_comb begin
    regwrite_d = (state_d == S_WB) && (instr_q[4:0] != 5'd31);
    memread_d  = is_ldur && ((state_d == S_MEM) || (state_d == S_WB));
    memwrite_d = is_stur && (state_d == S_MEM);
    done_d     = (state_d == S_DONE);
    illegal_d  = (state_d == S_ERR);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    Read1       = '0;
    Rm          = '0;
    Rt          = '0;
    WriteReg    = '0;
    SEin        = '0;
    OpcodeField = '0;
    ALUOp       = 2'b00;
    ALUSrc      = 2'b00;
    MemtoReg    = 2'b00;
    Reg2Loc     = 2'b00;
    if (!in_err) begin
      Read1       = instr_q[9:5];
      OpcodeField = opc;
      if (is_r) begin
        Rm       = instr_q[20:16];
        WriteReg = instr_q[4:0];
        ALUOp    = 2'b10;
      end
      if (is_ldur || is_stur) begin
        SEin   = instr_q[20:12];
        ALUSrc = 2'b01;
      end
      if (is_ldur) begin
        WriteReg = instr_q[4:0];
        MemtoReg = 2'b01;
      end
      if (is_stur) begin
        Rt      = instr_q[4:0];
        Reg2Loc = 2'b01;
      end
    end
  end

  // Ready is masked by reset so nothing looks acceptable while held in reset.
  assign InstrReady = Reset_n && (state_q == S_IDLE);
  assign RegWrite   = regwrite_q;
  assign MemRead    = memread_q;
  assign MemWrite   = memwrite_q;
  assign Done       = done_q;
  assign IllegalOp  = illegal_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_lab4_control_sequencer.sv
// Randomized self-checking bench for lab4_control_sequencer with a per-class
// timing/field reference model.
module tb_lab4_control_sequencer;

  localparam int CNT_W = 16;

  logic             Clock = 1'b0;
  logic             Reset_n;
  logic [31:0]      Instr;
  logic             InstrValid;
  logic             InstrReady;
  logic [4:0]       Read1, Rm, Rt, WriteReg;
  logic [8:0]       SEin;
  logic [10:0]      OpcodeField;
  logic [1:0]       ALUOp, ALUSrc, MemtoReg, Reg2Loc;
  logic             RegWrite, MemRead, MemWrite, Done, IllegalOp;
  logic [CNT_W-1:0] InstrCount;

  lab4_control_sequencer #(.CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Instr(Instr), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Read1(Read1), .Rm(Rm), .Rt(Rt), .WriteReg(WriteReg),
    .SEin(SEin), .OpcodeField(OpcodeField), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Done(Done), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fails = 0;
  logic [CNT_W-1:0] exp_count = '0;

  localparam int C_ILL = 0, C_R = 1, C_LD = 2, C_ST = 3;
  logic [10:0] r_ops [4] = '{11'b10001011000, 11'b11001011000,
                             11'b10001010000, 11'b10101010000};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int classify(input logic [10:0] opc);
    case (opc)
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: return C_R;
      11'b11111000010: return C_LD;
      11'b11111000000: return C_ST;
      default:         return C_ILL;
    endcase
  endfunction

  function automatic logic [47:0] exp_fields(input logic [31:0] ins, input bit err);
    int cls = classify(ins[31:21]);
    bit d   = (cls == C_LD) || (cls == C_ST);
    logic [4:0] rm  = (cls == C_R) ? ins[20:16] : 5'd0;
    logic [4:0] rt  = (cls == C_ST) ? ins[4:0] : 5'd0;
    logic [4:0] wr  = (cls == C_R || cls == C_LD) ? ins[4:0] : 5'd0;
    logic [8:0] se  = d ? ins[20:12] : 9'd0;
    logic [1:0] aop = (cls == C_R) ? 2'b10 : 2'b00;
    logic [1:0] src = d ? 2'b01 : 2'b00;
    logic [1:0] m2r = (cls == C_LD) ? 2'b01 : 2'b00;
    logic [1:0] r2l = (cls == C_ST) ? 2'b01 : 2'b00;
    if (err) return '0;
    return {ins[9:5], rm, rt, wr, se, ins[31:21], aop, src, m2r, r2l};
  endfunction

  function automatic logic [47:0] act_fields();
    return {Read1, Rm, Rt, WriteReg, SEin, OpcodeField, ALUOp, ALUSrc, MemtoReg, Reg2Loc};
  endfunction

  function automatic logic [5:0] act_strobes();
    return {RegWrite, MemRead, MemWrite, Done, IllegalOp, InstrReady};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [10:0] o;
    case ($urandom_range(0, 4))
      0, 1: w[31:21] = r_ops[$urandom_range(0, 3)];
      2:    w[31:21] = 11'b11111000010;
      3:    w[31:21] = 11'b11111000000;
      default: begin
        o = 11'($urandom);
        while (classify(o) != C_ILL) o = 11'($urandom);
        w[31:21] = o;
      end
    endcase
    return w;
  endfunction

  // Issue one instruction from a negedge with the DUT idle; checks every cycle
  // until it is back in IDLE. With noise, InstrValid stays high with junk while busy.
  task automatic run_instr(input logic [31:0] ins, input bit noise);
    int cls = classify(ins[31:21]);
    int lat = (cls == C_ILL) ? 2 : (cls == C_LD) ? 5 : 4;
    bit wr_en = (ins[4:0] != 5'd31);
    int guard = 0;
    logic rw, mr, mw, dn, il;
    while (!InstrReady && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    check_val("ready_before_issue", 64'(InstrReady), 64'd1);
    Instr = ins;
    InstrValid = 1'b1;
    for (int p = 1; p <= lat; p++) begin
      @(negedge Clock);
      rw = wr_en && ((cls == C_R && p == 3) || (cls == C_LD && p == 4));
      mr = (cls == C_LD) && (p == 3 || p == 4);
      mw = (cls == C_ST) && (p == 3);
      dn = (cls != C_ILL) && (p == lat);
      il = (cls == C_ILL) && (p == 2);
      check_val($sformatf("strobes_%08h_p%0d", ins, p), 64'(act_strobes()),
                64'({rw, mr, mw, dn, il, 1'b0}));
      check_val($sformatf("fields_%08h_p%0d", ins, p), 64'(act_fields()),
                64'(exp_fields(ins, cls == C_ILL && p == 2)));
      if (noise && p < lat) Instr = $urandom;
      else InstrValid = 1'b0;
    end
    @(negedge Clock);
    if (cls != C_ILL) exp_count = exp_count + 1'b1;
    check_val($sformatf("count_%08h", ins), 64'(InstrCount), 64'(exp_count));
    check_val($sformatf("idle_%08h", ins), 64'(act_strobes()), 64'b000001);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    InstrValid = 1'b0;
    Instr = '0;
    repeat (2) @(negedge Clock);
    check_val("rst_strobes", 64'(act_strobes()), 64'd0);
    check_val("rst_fields", 64'(act_fields()), 64'd0);
    check_val("rst_count", 64'(InstrCount), 64'd0);
    Reset_n = 1'b1;
    @(negedge Clock);
    check_val("post_rst_ready", 64'(act_strobes()), 64'b000001);

    run_instr(32'hF8428005, 1'b0);
    run_instr(32'h8B0A00A1, 1'b0);
    run_instr(32'hF8001001, 1'b0);
    run_instr(32'hCB0A00BF, 1'b0);
    run_instr(32'h00000000, 1'b0);
    run_instr(32'h8B0A00A1, 1'b1);
    run_instr(32'hF8428005, 1'b1);

    for (int i = 0; i < 60; i++) run_instr(rand_instr(), ($urandom_range(0, 1) == 1));

    // Reset while an LDUR sits in MEM.
    Instr = 32'hF8428005;
    InstrValid = 1'b1;
    @(negedge Clock);
    InstrValid = 1'b0;
    repeat (2) @(negedge Clock);
    check_val("mid_mem_memread", 64'(MemRead), 64'd1);
    #2 Reset_n = 1'b0;
    #1;
    check_val("async_strobes", 64'(act_strobes()), 64'd0);
    check_val("async_fields", 64'(act_fields()), 64'd0);
    check_val("async_count", 64'(InstrCount), 64'd0);
    exp_count = '0;
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      check_val($sformatf("post_abort_%0d", k), 64'(act_strobes()), 64'b000001);
      check_val($sformatf("post_abort_count_%0d", k), 64'(InstrCount), 64'd0);
    end

    run_instr(32'h8B0A00A1, 1'b0);
    run_instr(32'hF8001001, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
